// File: rtl/print_fanout_pkg.sv
// Shared types and constants for the print fan-out block.
// PRINT_LF_EXPAND_EN (optional) turns every LF into a CR+LF pair on the sinks.
package print_fanout_pkg;

  localparam int unsigned TIMER_WIDTH = 20;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // SEND_LF: broadcasting the CR that precedes a buffered LF
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    SEND_LF = 2'd2
  } state_t;

endpackage

// File: rtl/print_fifo.sv
// Synchronous FIFO with first-word fall-through head and occupancy count.
module print_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          Clock_1MHz,
  input  logic                          Rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two
  always_ff @(posedge Clock_1MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  always_ff @(posedge Clock_1MHz) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/print_fanout.sv
// Buffers the CPU print stream and broadcasts each character to several sinks.
// Optional PRINT_LF_EXPAND_EN: each LF is preceded by a CR on all sinks.
module print_fanout
  import print_fanout_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter int unsigned            FIFO_DEPTH     = 16,
  parameter int unsigned            SINKS          = 2,
  parameter logic [SINKS-1:0]       EDGE_RDY_MASK  = 2'b10,
  parameter logic [TIMER_WIDTH-1:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic                        Clock_1MHz,
  input  logic                        Rst_n,
  input  logic [DATA_WIDTH-1:0]       src_data,
  input  logic                        src_vld,
  output logic                        src_rdy,
  input  logic [SINKS-1:0]            sink_en,
  output logic [DATA_WIDTH-1:0]       sink_data,
  output logic [SINKS-1:0]            sink_vld,
  input  logic [SINKS-1:0]            sink_rdy,
  input  logic                        err_clr,
  output logic [SINKS-1:0]            timeout_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  state_t                  state;
  state_t                  state_nxt;
  logic [SINKS-1:0]        pending;
  logic [SINKS-1:0]        pending_nxt;
  logic [SINKS-1:0]        sync1;
  logic [SINKS-1:0]        sync2;
  logic [SINKS-1:0]        sync_prev;
  logic [SINKS-1:0]        rise;
  logic [SINKS-1:0]        done;
  logic [SINKS-1:0]        stuck;
  logic [SINKS-1:0]        remain;
  logic [SINKS-1:0]        err_nxt;
  logic [DATA_WIDTH-1:0]   head;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic [TIMER_WIDTH-1:0]  timer;
  logic [TIMER_WIDTH-1:0]  timer_nxt;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    timeout_hit;

  print_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock_1MHz (Clock_1MHz),
    .Rst_n      (Rst_n),
    .push       (src_vld),
    .pop        (pop),
    .din        (src_data),
    .dout       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  assign src_rdy  = ~fifo_full;
  assign sink_vld = pending;
  assign busy     = (state != IDLE) | ~fifo_empty;

  // Per-sink completion: synchronised rising edge or level handshake
  assign rise        = sync2 & ~sync_prev;
  assign done        = (EDGE_RDY_MASK & rise) | (~EDGE_RDY_MASK & pending & sink_rdy);
  assign stuck       = pending & sink_en & ~done;
  assign timeout_hit = (TIMEOUT_CYCLES != '0) &&
                       (timer == TIMEOUT_CYCLES - TIMER_WIDTH'(1));
  assign remain      = timeout_hit ? '0 : stuck;

  always_ff @(posedge Clock_1MHz or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty && (sink_en != '0)) begin
`ifdef PRINT_LF_EXPAND_EN
          state_nxt = (head == DATA_WIDTH'(ASCII_LF)) ? SEND_LF : SEND;
`else
          state_nxt = SEND;
`endif
        end
      end
      SEND:    if (remain == '0) state_nxt = IDLE;
      SEND_LF: if (remain == '0) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  // Pop, pending set, data load, timer and sticky error updates
  always_comb begin
    pop         = 1'b0;
    pending_nxt = pending;
    data_nxt    = sink_data;
    timer_nxt   = timer;
    err_nxt     = timeout_err & ~{SINKS{err_clr}};
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          pending_nxt = sink_en;
          timer_nxt   = '0;
`ifdef PRINT_LF_EXPAND_EN
          data_nxt    = (head == DATA_WIDTH'(ASCII_LF)) ? DATA_WIDTH'(ASCII_CR) : head;
`else
          data_nxt    = head;
`endif
        end
      end
      SEND, SEND_LF: begin
        pending_nxt = remain;
        timer_nxt   = timer + TIMER_WIDTH'(1);
        if (timeout_hit) err_nxt = err_nxt | stuck;
        // CR finished: re-broadcast the LF without another pop
        if ((state == SEND_LF) && (remain == '0)) begin
          pending_nxt = sink_en;
          data_nxt    = DATA_WIDTH'(ASCII_LF);
          timer_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock_1MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      pending     <= '0;
      sink_data   <= '0;
      timer       <= '0;
      timeout_err <= '0;
      sync1       <= '0;
      sync2       <= '0;
      sync_prev   <= '0;
    end else begin
      pending     <= pending_nxt;
      sink_data   <= data_nxt;
      timer       <= timer_nxt;
      timeout_err <= err_nxt;
      sync1       <= sink_rdy;
      sync2       <= sync1;
      sync_prev   <= sync2;
    end
  end

endmodule

// File: tb/tb_print_fanout.sv
// Directed bench for print_fanout (timeout shortened to 100 cycles).
module tb_print_fanout;

  logic       Clock_1MHz = 1'b0;
  logic       Rst_n      = 1'b0;
  logic [7:0] src_data   = '0;
  logic       src_vld    = 1'b0;
  logic       src_rdy;
  logic [1:0] sink_en    = '0;
  logic [7:0] sink_data;
  logic [1:0] sink_vld;
  logic [1:0] sink_rdy   = '0;
  logic       err_clr    = 1'b0;
  logic [1:0] timeout_err;
  logic [4:0] fifo_level;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  print_fanout #(
    .TIMEOUT_CYCLES (20'd100)
  ) dut (
    .Clock_1MHz  (Clock_1MHz),
    .Rst_n       (Rst_n),
    .src_data    (src_data),
    .src_vld     (src_vld),
    .src_rdy     (src_rdy),
    .sink_en     (sink_en),
    .sink_data   (sink_data),
    .sink_vld    (sink_vld),
    .sink_rdy    (sink_rdy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  always #5 Clock_1MHz = ~Clock_1MHz;

  task automatic tick;
    @(posedge Clock_1MHz);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vld1(input logic v, input string tag);
    int n;
    n = 0;
    while ((sink_vld[1] !== v) && (n < 30)) begin
      tick;
      n++;
    end
    check(tag, 32'(sink_vld[1]), 32'(v));
  endtask

  task automatic pulse1;
    sink_rdy[1] = 1'b1;
    tick;
    tick;
    sink_rdy[1] = 1'b0;
  endtask

  task automatic drain_one(input logic [7:0] exp);
    wait_vld1(1'b1, "drain_vld");
    check("drain_data", 32'(sink_data), 32'(exp));
    pulse1;
    wait_vld1(1'b0, "drain_done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge Clock_1MHz);
    #1;
    check("rst_src_rdy", 32'(src_rdy), 32'd1);
    check("rst_sink_vld", 32'(sink_vld), 32'd0);
    check("rst_sink_data", 32'(sink_data), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    Rst_n = 1'b1;
    tick;

    // Single character: sink 0 level, sink 1 edge
    sink_en  = 2'b11;
    sink_rdy = 2'b01;
    tick; cyc = 0;
    src_data = 8'h41; src_vld = 1'b1;
    goto(1); src_vld = 1'b0;
    check("t1_level", 32'(fifo_level), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    goto(2);
    check("t1_vld_c2", 32'(sink_vld), 32'b11);
    check("t1_data", 32'(sink_data), 32'h41);
    goto(3);
    check("t1_vld_c3", 32'(sink_vld), 32'b10);
    goto(10); sink_rdy[1] = 1'b1;
    goto(12);
    check("t1_vld_c12", 32'(sink_vld), 32'b10);
    sink_rdy[1] = 1'b0;
    goto(13);
    check("t1_vld_c13", 32'(sink_vld), 32'b00);
    goto(14);
    check("t1_busy_end", 32'(busy), 32'd0);

    // FIFO full: one character in SEND plus 16 buffered
    sink_rdy = 2'b00;
    tick; cyc = 0;
    for (int i = 0; i < 17; i++) begin
      src_data = 8'(8'h30 + i);
      src_vld  = 1'b1;
      check("full_rdy_accept", 32'(src_rdy), 32'd1);
      if (i == 16) check("full_level15", 32'(fifo_level), 32'd15);
      tick;
    end
    src_data = 8'h41;
    check("full_rdy_held", 32'(src_rdy), 32'd0);
    check("full_level16", 32'(fifo_level), 32'd16);
    tick;
    check("full_rdy_still", 32'(src_rdy), 32'd0);
    check("full_level_still", 32'(fifo_level), 32'd16);
    check("full_vld", 32'(sink_vld), 32'b11);
    src_vld     = 1'b0;
    sink_rdy[0] = 1'b1;
    for (int k = 0; k < 17; k++) drain_one(8'(8'h30 + k));
    tick;
    check("full_level_end", 32'(fifo_level), 32'd0);
    check("full_busy_end", 32'(busy), 32'd0);

    // Disable sink 1 mid-transfer
    sink_rdy = 2'b00;
    tick; cyc = 0;
    src_data = 8'h55; src_vld = 1'b1;
    goto(1); src_vld = 1'b0;
    goto(2);
    check("dis_vld_c2", 32'(sink_vld), 32'b11);
    goto(3); sink_en = 2'b01;
    goto(4);
    check("dis_vld_c4", 32'(sink_vld), 32'b01);
    sink_rdy[0] = 1'b1;
    goto(5);
    check("dis_vld_c5", 32'(sink_vld), 32'b00);
    check("dis_err", 32'(timeout_err), 32'd0);
    check("dis_busy", 32'(busy), 32'd0);
    sink_en = 2'b11;

    // Reset in the middle of a transfer
    sink_rdy = 2'b00;
    tick; cyc = 0;
    src_data = 8'h77; src_vld = 1'b1;
    goto(1); src_data = 8'h78;
    goto(2); src_vld = 1'b0;
    goto(3);
    check("mrst_vld_before", 32'(sink_vld), 32'b11);
    check("mrst_level_before", 32'(fifo_level), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("mrst_vld", 32'(sink_vld), 32'd0);
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_data", 32'(sink_data), 32'd0);
    check("mrst_src_rdy", 32'(src_rdy), 32'd1);
    tick;
    Rst_n = 1'b1;
    tick;

    // Timeout on sink 1, err_clr and set-over-clear priority
    sink_rdy = 2'b01;
    tick; cyc = 0;
    src_data = 8'h66; src_vld = 1'b1;
    goto(1); src_vld = 1'b0;
    goto(5); src_data = 8'h67; src_vld = 1'b1;
    goto(6); src_vld = 1'b0;
    check("to_level", 32'(fifo_level), 32'd1);
    goto(101);
    check("to_vld_c101", 32'(sink_vld), 32'b10);
    check("to_err_c101", 32'(timeout_err), 32'b00);
    goto(102);
    check("to_vld_c102", 32'(sink_vld), 32'b00);
    check("to_err_c102", 32'(timeout_err), 32'b10);
    goto(103);
    check("to_next_vld", 32'(sink_vld), 32'b11);
    check("to_next_data", 32'(sink_data), 32'h67);
    goto(110); err_clr = 1'b1;
    goto(111); err_clr = 1'b0;
    check("to_err_clr", 32'(timeout_err), 32'b00);
    goto(202); err_clr = 1'b1;
    check("to_vld_c202", 32'(sink_vld), 32'b10);
    goto(203); err_clr = 1'b0;
    check("to_set_wins", 32'(timeout_err), 32'b10);
    check("to_vld_c203", 32'(sink_vld), 32'b00);
    goto(204); err_clr = 1'b1;
    goto(205); err_clr = 1'b0;
    check("to_err_clr2", 32'(timeout_err), 32'b00);
    check("to_busy", 32'(busy), 32'd0);

    // All sinks disabled: characters are discarded one per cycle
    sink_en = 2'b00;
    tick; cyc = 0;
    for (int i = 0; i < 5; i++) begin
      src_data = 8'(8'h50 + i);
      src_vld  = 1'b1;
      tick;
      check("dis_all_vld", 32'(sink_vld), 32'b00);
      check("dis_all_level", 32'(fifo_level), 32'd1);
    end
    src_vld = 1'b0;
    tick;
    check("dis_all_level_end", 32'(fifo_level), 32'd0);
    check("dis_all_vld_end", 32'(sink_vld), 32'b00);
    check("dis_all_busy", 32'(busy), 32'd0);

    // Line feed handling
    sink_en  = 2'b11;
    sink_rdy = 2'b01;
    tick; cyc = 0;
    src_data = 8'h0A; src_vld = 1'b1;
    goto(1); src_vld = 1'b0;
    check("lf_level_c1", 32'(fifo_level), 32'd1);
    goto(2);
    check("lf_level_c2", 32'(fifo_level), 32'd0);
    check("lf_vld_c2", 32'(sink_vld), 32'b11);
`ifdef PRINT_LF_EXPAND_EN
    check("lf_cr_data", 32'(sink_data), 32'h0D);
    goto(3); sink_rdy[1] = 1'b1;
    goto(5); sink_rdy[1] = 1'b0;
    check("lf_vld_c5", 32'(sink_vld), 32'b10);
    goto(6);
    check("lf_vld_c6", 32'(sink_vld), 32'b11);
    check("lf_lf_data", 32'(sink_data), 32'h0A);
    check("lf_level_c6", 32'(fifo_level), 32'd0);
    goto(7); sink_rdy[1] = 1'b1;
    goto(9); sink_rdy[1] = 1'b0;
    goto(10);
    check("lf_vld_c10", 32'(sink_vld), 32'b00);
    goto(11);
    check("lf_busy", 32'(busy), 32'd0);
`else
    check("lf_data", 32'(sink_data), 32'h0A);
    goto(3); sink_rdy[1] = 1'b1;
    goto(5); sink_rdy[1] = 1'b0;
    goto(6);
    check("lf_vld_c6", 32'(sink_vld), 32'b00);
    goto(7);
    check("lf_busy", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
